// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared widths, latencies, CPU sequencer states and byte-merge helper for the VRAM arbiter
package vram_arb_pkg;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int VID_LAT = 3;
  localparam int CPU_RD_LAT = 3;
  localparam int CPU_WR_LAT = 2;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, HOLD} cpu_state_t;
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] base, input logic [DW-1:0] upd, input logic [1:0] be);
    return {be[1] ? upd[15:8] : base[15:8], be[0] ? upd[7:0] : base[7:0]};
  endfunction
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: raster, CPU and VRAM-macro signals of the arbiter; slave = arbiter side, master = surroundings
interface vram_arbiter_if;
  import vram_arb_pkg::*;
  logic vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic vid_valid;
  logic cpu_stb;
  logic cpu_we;
  logic [1:0] cpu_wtbt;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic cpu_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic mem_we;
  logic [1:0] mem_be;
  logic [DW-1:0] mem_dout;
  modport slave (
    input vid_req, vid_addr, cpu_stb, cpu_we, cpu_wtbt, cpu_addr, cpu_din, mem_dout,
    output vid_data, vid_valid, cpu_dout, cpu_ack, mem_addr, mem_din, mem_we, mem_be
  );
  modport master (
    output vid_req, vid_addr, cpu_stb, cpu_we, cpu_wtbt, cpu_addr, cpu_din, mem_dout,
    input vid_data, vid_valid, cpu_dout, cpu_ack, mem_addr, mem_din, mem_we, mem_be
  );
endinterface

// File: rtl/vram_wr_buf.sv
// vram_wr_buf: one-entry posted CPU write, drain bookkeeping and byte-merge forwarding into video reads
module vram_wr_buf
  import vram_arb_pkg::*;
(
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic [1:0]    be_i,
  input  logic          drain_i,
  input  logic          vid_req_i,
  input  logic [AW-1:0] vid_addr_i,
  input  logic [DW-1:0] rdata_i,
  output logic          vld_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic [1:0]    be_o,
  output logic [DW-1:0] fwd_data_o
);
  logic vld_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q, f1_data_q, f2_data_q;
  logic [1:0] be_q, f1_be_q, f2_be_q;
  // entry holds until drained; a video hit carries the entry along the 2-cycle RAM read latency
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      be_q <= '0;
      f1_data_q <= '0;
      f1_be_q <= '0;
      f2_data_q <= '0;
      f2_be_q <= '0;
    end else begin
      vld_q <= load_i || (vld_q && !drain_i);
      if (load_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
        be_q <= be_i;
      end
      f1_be_q <= (vid_req_i && vld_q && vid_addr_i == addr_q) ? be_q : 2'b00;
      f1_data_q <= data_q;
      f2_be_q <= f1_be_q;
      f2_data_q <= f1_data_q;
    end
  end
  assign vld_o = vld_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign be_o = be_q;
  assign fwd_data_o = merge_bytes(rdata_i, f2_data_q, f2_be_q);
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: VRAM slot arbiter, raster fetch has absolute priority, CPU stb/ack sequenced into free slots; VRAM_ARB_POSTED_WR_EN adds a posted write buffer
module vram_arbiter
  import vram_arb_pkg::*;
(
  input logic clk_sys,
  input logic reset_n,
  vram_arbiter_if.slave bus
);
  cpu_state_t state_q;
  logic we_q, ack_q;
  logic [VID_LAT-1:0] vid_pipe_q;
  logic [DW-1:0] vid_data_q, cpu_dout_q, mem_din_q, mem_din_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic mem_we_q, mem_we_d;
  logic [1:0] mem_be_q, mem_be_d;
  logic idle_stb, rd_go, wr_go, cmd_go, drain, buf_vld;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data, vid_rdata;
  logic [1:0] buf_be;
`ifdef VRAM_ARB_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
  vram_wr_buf u_wr_buf (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .load_i     (wr_go && bus.cpu_wtbt != 2'b00),
    .addr_i     (bus.cpu_addr),
    .data_i     (bus.cpu_din),
    .be_i       (bus.cpu_wtbt),
    .drain_i    (drain),
    .vid_req_i  (bus.vid_req),
    .vid_addr_i (bus.vid_addr),
    .rdata_i    (bus.mem_dout),
    .vld_o      (buf_vld),
    .addr_o     (buf_addr),
    .data_o     (buf_data),
    .be_o       (buf_be),
    .fwd_data_o (vid_rdata)
  );
`else
  localparam bit POSTED = 1'b0;
  assign buf_vld = 1'b0;
  assign buf_addr = '0;
  assign buf_data = '0;
  assign buf_be = '0;
  assign vid_rdata = bus.mem_dout;
`endif
  // a full buffer blocks new CPU accesses so it always drains before the next read or write
  assign idle_stb = (state_q == IDLE) && bus.cpu_stb;
  assign rd_go = idle_stb && !bus.cpu_we && !bus.vid_req && !buf_vld;
  assign wr_go = idle_stb && bus.cpu_we && !buf_vld && (POSTED || !bus.vid_req);
  assign cmd_go = rd_go || (wr_go && !POSTED);
  assign drain = buf_vld && !bus.vid_req;
  // slot owner: video, then buffer drain, then a CPU command; idle slots keep address and data
  always_comb begin
    mem_addr_d = bus.vid_req ? bus.vid_addr : drain ? buf_addr : cmd_go ? bus.cpu_addr : mem_addr_q;
    mem_din_d = drain ? buf_data : cmd_go ? bus.cpu_din : mem_din_q;
    mem_we_d = drain || (cmd_go && bus.cpu_we && bus.cpu_wtbt != 2'b00);
    mem_be_d = bus.vid_req ? 2'b11 : drain ? buf_be : cmd_go ? (bus.cpu_we ? bus.cpu_wtbt : 2'b11) : mem_be_q;
  end
  // CPU sequencer: one access per stb, ack pulse registered, then wait for stb to drop
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      ack_q <= 1'b0;
      cpu_dout_q <= '0;
    end else begin
      ack_q <= (state_q == WAIT) || (state_q == ISSUE && we_q);
      case (state_q)
        IDLE: if (rd_go || wr_go) begin
          state_q <= ISSUE;
          we_q <= bus.cpu_we;
        end
        ISSUE: state_q <= we_q ? ACK : WAIT;
        WAIT: begin
          state_q <= ACK;
          cpu_dout_q <= bus.mem_dout;
        end
        ACK: state_q <= HOLD;
        HOLD: if (!bus.cpu_stb) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // registered RAM command and fixed-latency video return
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      mem_addr_q <= '0;
      mem_din_q <= '0;
      mem_we_q <= 1'b0;
      mem_be_q <= '0;
      vid_pipe_q <= '0;
      vid_data_q <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      mem_we_q <= mem_we_d;
      mem_be_q <= mem_be_d;
      vid_pipe_q <= {vid_pipe_q[VID_LAT-2:0], bus.vid_req};
      if (vid_pipe_q[VID_LAT-2]) vid_data_q <= vid_rdata;
    end
  end
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din = mem_din_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_be = mem_be_q;
  assign bus.vid_valid = vid_pipe_q[VID_LAT-1];
  assign bus.vid_data = vid_data_q;
  assign bus.cpu_ack = ack_q;
  assign bus.cpu_dout = cpu_dout_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of slot arbitration, latencies, reset and optional write posting
module tb_vram_arbiter;
  import vram_arb_pkg::*;
  typedef struct {int c; logic [31:0] d;} ev_t;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  ev_t vq[$];
  ev_t aq[$];
  logic [15:0] ram [0:16383];
  logic pk_en = 1'b0;
  logic [13:0] pk_a = '0;
  logic [15:0] pk_d = '0;
  vram_arbiter_if bus();
  vram_arbiter dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(posedge clk_sys) begin
    if (pk_en) ram[pk_a] <= pk_d;
    if (bus.mem_we && bus.mem_be[0]) ram[bus.mem_addr][7:0] <= bus.mem_din[7:0];
    if (bus.mem_we && bus.mem_be[1]) ram[bus.mem_addr][15:8] <= bus.mem_din[15:8];
    bus.mem_dout <= ram[bus.mem_addr];
  end
  always @(negedge clk_sys) begin
    if (bus.vid_valid) vq.push_back('{c: cyc, d: 32'(bus.vid_data)});
    if (bus.cpu_ack) aq.push_back('{c: cyc, d: 32'(bus.cpu_dout)});
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask
  task automatic poke(input logic [13:0] a, input logic [15:0] d);
    pk_en = 1'b1;
    pk_a = a;
    pk_d = d;
    tick;
    pk_en = 1'b0;
  endtask
  function automatic ev_t vget(input int k);
    ev_t e;
    e.c = -1;
    e.d = '1;
    if (k < vq.size()) e = vq[k];
    return e;
  endfunction
  function automatic ev_t aget(input int k);
    ev_t e;
    e.c = -1;
    e.d = '1;
    if (k < aq.size()) e = aq[k];
    return e;
  endfunction
  task automatic chk_reset(input string p);
    chk({p, "vid_valid"}, 32'(bus.vid_valid), 0);
    chk({p, "cpu_ack"}, 32'(bus.cpu_ack), 0);
    chk({p, "mem_we"}, 32'(bus.mem_we), 0);
    chk({p, "mem_be"}, 32'(bus.mem_be), 0);
    chk({p, "mem_addr"}, 32'(bus.mem_addr), 0);
    chk({p, "mem_din"}, 32'(bus.mem_din), 0);
    chk({p, "vid_data"}, 32'(bus.vid_data), 0);
    chk({p, "cpu_dout"}, 32'(bus.cpu_dout), 0);
  endtask
  initial begin
    int n;
    int rd;
    int vrc[$];
    bus.vid_req = 1'b0;
    bus.vid_addr = '0;
    bus.cpu_stb = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_wtbt = '0;
    bus.cpu_addr = '0;
    bus.cpu_din = '0;
    poke(14'h1234, 16'hA5C3);
    poke(14'h0100, 16'h1111);
    poke(14'h0200, 16'h1357);
    poke(14'h0300, 16'h2468);
    poke(14'h0700, 16'h9999);
    poke(14'h0800, 16'hAB00);
    for (int i = 0; i < 24; i++) poke(14'h0400 + 14'(i), 16'h5000 + 16'(i));
    for (int i = 0; i < 3; i++) poke(14'h0600 + 14'(i), 16'h7000 + 16'(i));
    @(negedge clk_sys);
    chk_reset("rst_");
    tick;
    reset_n = 1'b1;
    repeat (2) tick;
    // video read only
    vq.delete(); aq.delete();
    n = cyc;
    bus.vid_req = 1'b1;
    bus.vid_addr = 14'h1234;
    tick;
    bus.vid_req = 1'b0;
    repeat (6) tick;
    chk("vid_cnt", vq.size(), 1);
    chk("vid_lat", vget(0).c - n, VID_LAT);
    chk("vid_data", vget(0).d, 'hA5C3);
    chk("vid_no_ack", aq.size(), 0);
    // CPU high-byte write with stb held long after ack
    vq.delete(); aq.delete();
    n = cyc;
    bus.cpu_stb = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_wtbt = 2'b10;
    bus.cpu_addr = 14'h0100;
    bus.cpu_din = 16'hBEEF;
    repeat (6) tick;
    bus.cpu_stb = 1'b0;
    bus.cpu_we = 1'b0;
    repeat (4) tick;
    chk("wr_ack_cnt", aq.size(), 1);
    chk("wr_lat", aget(0).c - n, CPU_WR_LAT);
    chk("wr_ram", 32'(ram[14'h0100]), 'hBE11);
    // contention: video and CPU read strobe in the same cycle
    vq.delete(); aq.delete();
    n = cyc;
    bus.vid_req = 1'b1;
    bus.vid_addr = 14'h0300;
    bus.cpu_stb = 1'b1;
    bus.cpu_addr = 14'h0200;
    tick;
    bus.vid_req = 1'b0;
    @(negedge clk_sys);
    chk("ct_vid_cmd_addr", 32'(bus.mem_addr), 'h0300);
    chk("ct_vid_cmd_we", 32'(bus.mem_we), 0);
    tick;
    @(negedge clk_sys);
    chk("ct_cpu_cmd_addr", 32'(bus.mem_addr), 'h0200);
    chk("ct_cpu_cmd_be", 32'(bus.mem_be), 3);
    chk("ct_cpu_cmd_we", 32'(bus.mem_we), 0);
    repeat (4) tick;
    bus.cpu_stb = 1'b0;
    repeat (3) tick;
    chk("ct_vid_lat", vget(0).c - n, VID_LAT);
    chk("ct_vid_data", vget(0).d, 'h2468);
    chk("ct_ack_cnt", aq.size(), 1);
    chk("ct_ack_lat", aget(0).c - n, CPU_RD_LAT + 1);
    chk("ct_rd_data", aget(0).d, 'h1357);
    // video requests every other cycle while three CPU reads run
    vq.delete(); aq.delete();
    rd = 0;
    bus.cpu_stb = 1'b1;
    bus.cpu_addr = 14'h0600;
    for (int i = 0; i < 32; i++) begin
      bus.vid_req = (i % 2 == 0) && (i < 24);
      bus.vid_addr = 14'h0400 + 14'(i);
      if (bus.vid_req) vrc.push_back(cyc);
      tick;
      if (bus.cpu_stb && aq.size() > rd) begin
        bus.cpu_stb = 1'b0;
        rd++;
      end else if (!bus.cpu_stb && rd < 3) begin
        bus.cpu_stb = 1'b1;
        bus.cpu_addr = 14'h0600 + 14'(rd);
      end
    end
    bus.vid_req = 1'b0;
    bus.cpu_stb = 1'b0;
    repeat (5) tick;
    chk("alt_vid_cnt", vq.size(), 12);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("alt_vid_lat%0d", k), vget(k).c - vrc[k], VID_LAT);
      chk($sformatf("alt_vid_data%0d", k), vget(k).d, 'h5000 + 2 * k);
    end
    chk("alt_ack_cnt", aq.size(), 3);
    for (int k = 0; k < 3; k++) chk($sformatf("alt_rd_data%0d", k), aget(k).d, 'h7000 + k);
    // reset while a CPU read is in WAIT and a video fetch is in flight
    vq.delete(); aq.delete();
    bus.cpu_stb = 1'b1;
    bus.cpu_addr = 14'h0700;
    tick;
    bus.vid_req = 1'b1;
    bus.vid_addr = 14'h1234;
    tick;
    bus.vid_req = 1'b0;
    bus.cpu_stb = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick;
    reset_n = 1'b1;
    repeat (5) tick;
    chk("mid_rst_no_ack", aq.size(), 0);
    chk("mid_rst_no_vid", vq.size(), 0);
    @(negedge clk_sys);
    chk_reset("post_rst_");
    tick;
    n = cyc;
    bus.cpu_stb = 1'b1;
    bus.cpu_addr = 14'h0200;
    repeat (5) tick;
    bus.cpu_stb = 1'b0;
    repeat (2) tick;
    chk("post_rst_ack_cnt", aq.size(), 1);
    chk("post_rst_rd_lat", aget(0).c - n, CPU_RD_LAT);
    chk("post_rst_rd_data", aget(0).d, 'h1357);
`ifdef VRAM_ARB_POSTED_WR_EN
    // posted low-byte write, then video read of the same word before it drains
    vq.delete(); aq.delete();
    n = cyc;
    bus.cpu_stb = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_wtbt = 2'b01;
    bus.cpu_addr = 14'h0800;
    bus.cpu_din = 16'h00FF;
    tick;
    bus.vid_req = 1'b1;
    bus.vid_addr = 14'h0800;
    tick;
    bus.vid_req = 1'b0;
    repeat (3) tick;
    bus.cpu_stb = 1'b0;
    bus.cpu_we = 1'b0;
    repeat (4) tick;
    chk("pw_ack_lat", aget(0).c - n, 2);
    chk("pw_vid_lat", vget(0).c - (n + 1), VID_LAT);
    chk("pw_vid_data", vget(0).d, 'hABFF);
    chk("pw_ram", 32'(ram[14'h0800]), 'hABFF);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port 16K×16 video RAM between the raster fetch path and the CPU bus. The raster fetch has fixed latency and absolute priority. CPU reads and writes are sequenced into the free memory cycles with a bus-style stb/ack handshake. The block sits between the video timing block, the CPU bus decoder and the VRAM macro, and runs entirely in the clk_sys domain.

## Interface
- No parameters; widths fixed (14-bit word address, 16-bit data).
- clk_sys  in  1  system clock; every edge is a potential memory slot.
- reset_n  in  1  synchronous, active-low reset.
- vid_req  in  1  one-cycle raster fetch strobe.
- vid_addr  in  14  raster word address (bank, line, column).
- vid_data  out  16  fetched word.
- vid_valid  out  1  one-cycle pulse qualifying vid_data.
- cpu_stb  in  1  CPU request, held until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_wtbt  in  2  byte enables for writes ([1] = high byte).
- cpu_addr  in  14  CPU word address.
- cpu_din  in  16  write data.
- cpu_dout  out  16  read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- mem_addr  out  14  registered RAM address.
- mem_din  out  16  registered RAM write data.
- mem_we  out  1  registered RAM write enable.
- mem_be  out  2  registered RAM byte enables.
- mem_dout  in  16  RAM read data, one clock after the command.

## Operation
- Memory pipeline: command registered in cycle n+1 from a decision made in cycle n; RAM data is present in cycle n+2. The port accepts one command per cycle.
- Video priority: when vid_req is high, the slot belongs to video, unconditionally.
- CPU FSM states:
  - IDLE: wait for a new request.
  - ISSUE: CPU command on the mem_* outputs for one cycle.
  - WAIT: read data in flight.
  - ACK: cpu_ack pulse.
  - HOLD: wait for cpu_stb low.
- CPU FSM transitions:
  - IDLE → ISSUE when cpu_stb=1 and vid_req=0. The CPU command is latched in that cycle.
  - ISSUE → WAIT on reads; ISSUE → ACK on writes.
  - WAIT → ACK.
  - ACK → HOLD.
  - HOLD → IDLE once cpu_stb=0. A held stb never causes a second access.
- Writes: mem_be = cpu_wtbt. If cpu_wtbt=00, no RAM write is made (mem_we stays 0), but cpu_ack is still issued.
- Reads: mem_be = 11 and mem_we = 0. cpu_dout holds its value until the next read completes.
- Idle slots drive mem_we = 0; mem_addr keeps its last value.
- Upstream guarantee: vid_req is never high in two consecutive cycles, so the CPU cannot starve.

## Timing
- Reset values: vid_valid=0, cpu_ack=0, mem_we=0, mem_be=00, mem_addr=0, mem_din=0, vid_data=0, cpu_dout=0, FSM=IDLE.
- Video latency: vid_req in cycle n → mem command in n+1 → vid_valid and vid_data in n+3.
- CPU read latency: granted in cycle g → cpu_ack in g+3. CPU write latency: granted in g → cpu_ack in g+2.
- Contention: if vid_req and a new cpu_stb arrive in the same cycle, the CPU grant slips by exactly one cycle.
- vid_req while the CPU is in ISSUE, WAIT or ACK: the video command is issued in the following cycle, with no stall.
- Reset mid-operation: the in-flight CPU access is abandoned with no cpu_ack; a pending vid_valid is suppressed. A RAM write already presented on mem_* completes inside the RAM.

## Configuration
- VRAM_ARB_POSTED_WR_EN defined:
  - Adds a one-entry write buffer.
  - A CPU write is acked two cycles after its stb is sampled, with no memory slot needed.
  - The buffer commits in the first cycle with vid_req=0 and no CPU read issuing.
  - A write arriving while the buffer is full waits until the buffer drains.
  - A CPU read with the buffer full drains the buffer first.
  - A video read whose address equals the buffered address returns the buffered bytes merged per byte-enable.
- Macro undefined: the write buffer and forwarding logic are absent; writes behave as in Operation.

## Structure
- Package vram_arb_pkg: the FSM state enum, latency constants VID_LAT=3, CPU_RD_LAT=3, CPU_WR_LAT=2, and the address/data width constants.
- One sub-module, vram_wr_buf: holds the posted-write entry, drain request and byte-merge forwarding. It is instantiated only under VRAM_ARB_POSTED_WR_EN.

## Test plan
- Video read only: vid_addr=0x1234, RAM word 0xA5C3 → vid_valid in cycle n+3 with vid_data=0xA5C3; cpu_ack stays 0.
- CPU write 0xBEEF to 0x0100 with wtbt=10, prior content 0x1111 → RAM reads 0xBE11; cpu_ack in g+2; held stb gives no second ack.
- Contention: vid_req and cpu_stb (read) in the same cycle → video command in n+1, CPU command in n+2, cpu_ack in n+4.
- vid_req in alternating cycles during CPU reads → every vid_valid at exactly n+3; every CPU read completes with the correct data.
- reset_n low during CPU WAIT → no cpu_ack; after release, all outputs are at reset values and the FSM is IDLE.
- With VRAM_ARB_POSTED_WR_EN: a write of 0x00FF, wtbt=01, then a video read of the same address whose RAM word is 0xAB00 → vid_data=0xABFF; after the drain slot, the RAM holds 0xABFF.
